// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the digit-serial adder family: controller state
// encoding and a helper that derives the digit count from the widths.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } adder_state_e;

    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Request/result bundle of the multicycle adder. The master issues operands
// and start; the slave (the adder) returns the registered result and status.
interface multicycle_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, sub, cin, a, b,
        input  sum, cout, ovf, busy, done
    );

    modport slave (
        input  start, sub, cin, a, b,
        output sum, cout, ovf, busy, done
    );
endinterface

// File: rtl/multicycle_adder_digit_adder.sv
// One-bit full adder cell and the DIGIT-wide ripple chain built from it.
// The chain also exposes the carry entering its MSB so overflow can be formed.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);
    // Each stage keeps its own carry nets so the chain is not one
    // self-referencing vector.
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        logic c_in;
        logic c_out;
        if (gi == 0) begin : g_first
            assign c_in = c_i;
        end else begin : g_next
            assign c_in = g_bit[gi-1].c_out;
        end
        full_adder u_fa (
            .a_i (a_i[gi]),
            .b_i (b_i[gi]),
            .c_i (c_in),
            .s_o (s_o[gi]),
            .c_o (c_out)
        );
    end

    assign c_o     = g_bit[DIGIT-1].c_out;
    assign c_msb_o = g_bit[DIGIT-1].c_in;
endmodule

// File: rtl/multicycle_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice per RUN cycle, LSB first,
// result/cout/ovf registered on entry to DONE and held until the next result.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_adder_if.slave bus
);
    localparam int N  = digit_count(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    adder_state_e     state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_cmsb;

    // Operands shift right each cycle, so the active digit is always the low slice.
    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .s_o     (dig_sum),
        .c_o     (dig_cout),
        .c_msb_o (dig_cmsb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert B and force the first carry.
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
                    idx_d   = '0;
                    part_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dig_cout;
                part_d  = (part_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                if (idx_q == LAST) begin
                    sum_d   = part_d;
                    cout_d  = dig_cout;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: four width/digit configurations driven with the
// same operands, each checked every cycle against an arithmetic model.
module tb_multicycle_adder;
    localparam int NCFG = 4;
    localparam int CFG_W [NCFG] = '{16, 16, 16, 12};
    localparam int CFG_D [NCFG] = '{4, 1, 16, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_drv = 1'b0;
    logic        sub_drv   = 1'b0;
    logic        cin_drv   = 1'b0;
    logic [15:0] a_drv     = '0;
    logic [15:0] b_drv     = '0;

    logic [15:0]     obs_sum [NCFG];
    logic [15:0]     exp_sum [NCFG];
    logic [NCFG-1:0] obs_cout, obs_ovf, obs_busy, obs_done;
    logic [NCFG-1:0] exp_cout, exp_ovf, exp_busy, exp_done;

    int checks = 0;
    int errors = 0;
    int dcnt   = 0;

    logic        lit_en   = 1'b0;
    string       lit_name = "";
    logic [15:0] lit_sum  = '0;
    logic        lit_cout = 1'b0;
    logic        lit_ovf  = 1'b0;
    int          lit_dcnt = 0;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W = CFG_W[gi];
        localparam int D = CFG_D[gi];
        localparam int N = W / D;

        multicycle_adder_if #(.WIDTH(W)) bus ();

        multicycle_adder #(.WIDTH(W), .DIGIT(D)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.start = start_drv;
        assign bus.sub   = sub_drv;
        assign bus.cin   = cin_drv;
        assign bus.a     = a_drv[W-1:0];
        assign bus.b     = b_drv[W-1:0];

        // Reference: whole-word arithmetic, result appearing N edges after acceptance.
        logic [W-1:0] opa, opb;
        logic         cin_eff;
        logic [W:0]   full;
        assign opa     = a_drv[W-1:0];
        assign opb     = sub_drv ? ~b_drv[W-1:0] : b_drv[W-1:0];
        assign cin_eff = sub_drv ? 1'b1 : cin_drv;
        assign full    = {1'b0, opa} + {1'b0, opb} + {{W{1'b0}}, cin_eff};

        int           cnt = 0;
        logic [W-1:0] m_sum, p_sum;
        logic         m_cout, m_ovf, p_cout, p_ovf;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt    <= 0;
                m_sum  <= '0;
                m_cout <= 1'b0;
                m_ovf  <= 1'b0;
                p_sum  <= '0;
                p_cout <= 1'b0;
                p_ovf  <= 1'b0;
            end else if (cnt == 0) begin
                if (start_drv) begin
                    cnt    <= N + 1;
                    p_sum  <= full[W-1:0];
                    p_cout <= full[W];
                    p_ovf  <= (opa[W-1] == opb[W-1]) && (full[W-1] != opa[W-1]);
                end
            end else begin
                cnt <= cnt - 1;
                if (cnt == 2) begin
                    m_sum  <= p_sum;
                    m_cout <= p_cout;
                    m_ovf  <= p_ovf;
                end
            end
        end

        assign obs_sum[gi]  = 16'(bus.sum);
        assign obs_cout[gi] = bus.cout;
        assign obs_ovf[gi]  = bus.ovf;
        assign obs_busy[gi] = bus.busy;
        assign obs_done[gi] = bus.done;
        assign exp_sum[gi]  = 16'(m_sum);
        assign exp_cout[gi] = m_cout;
        assign exp_ovf[gi]  = m_ovf;
        assign exp_busy[gi] = (cnt != 0);
        assign exp_done[gi] = (cnt == 1);
    end

    // Single compare process: model check every cycle plus literal pins on config 0.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NCFG; i++) begin
                checks++;
                if ({obs_sum[i], obs_cout[i], obs_ovf[i], obs_busy[i], obs_done[i]} !==
                    {exp_sum[i], exp_cout[i], exp_ovf[i], exp_busy[i], exp_done[i]}) begin
                    errors++;
                    if (errors <= 30)
                        $display("FAIL cycle_cfg%0d t=%0t: got sum=%h cout=%b ovf=%b busy=%b done=%b, want sum=%h cout=%b ovf=%b busy=%b done=%b",
                                 i, $time, obs_sum[i], obs_cout[i], obs_ovf[i], obs_busy[i], obs_done[i],
                                 exp_sum[i], exp_cout[i], exp_ovf[i], exp_busy[i], exp_done[i]);
                end
            end
            if (obs_done[0]) dcnt++;
            if (lit_en) begin
                checks++;
                if (obs_sum[0] !== lit_sum || obs_cout[0] !== lit_cout || obs_ovf[0] !== lit_ovf ||
                    obs_busy[0] !== 1'b0 || dcnt != lit_dcnt) begin
                    errors++;
                    $display("FAIL %s: got sum=%h cout=%b ovf=%b busy=%b pulses=%0d, want sum=%h cout=%b ovf=%b busy=0 pulses=%0d",
                             lit_name, obs_sum[0], obs_cout[0], obs_ovf[0], obs_busy[0], dcnt,
                             lit_sum, lit_cout, lit_ovf, lit_dcnt);
                end
                dcnt = 0;
            end
        end
    end

    task automatic set_lit(input string name, input logic [15:0] s, input logic c,
                           input logic o, input int pulses);
        lit_name = name;
        lit_sum  = s;
        lit_cout = c;
        lit_ovf  = o;
        lit_dcnt = pulses;
        lit_en   = 1'b1;
        @(negedge clk);
        #1 lit_en = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input bit disturb,
                          input bit do_lit, input logic [15:0] es, input logic ec, input logic eo);
        @(posedge clk); #2;
        a_drv = a; b_drv = b; cin_drv = cin; sub_drv = sub; start_drv = 1'b1;
        @(posedge clk); #2;
        if (disturb) begin
            a_drv = ~a; b_drv = a ^ b; sub_drv = ~sub; cin_drv = ~cin;
            repeat (2) @(posedge clk);
            #2;
        end
        start_drv = 1'b0;
        repeat (18) @(posedge clk);
        #2;
        $display("op %-14s a=%h b=%h cin=%b sub=%b -> cfg0 sum=%h cout=%b ovf=%b",
                 name, a, b, cin, sub, obs_sum[0], obs_cout[0], obs_ovf[0]);
        if (do_lit) set_lit(name, es, ec, eo, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        set_lit("reset_state", 16'h0000, 1'b0, 1'b0, 0);
        rst = 1'b0;

        run_op("add_basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        run_op("add_wrap",    16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        run_op("add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        run_op("sub_neg",     16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("add_zero",    16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        run_op("add_negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
        run_op("add_allones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("sub_zero",    16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_op("busy_ignore", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5555, 1'b0, 1'b0);

        // Abort mid-RUN with rst between edges; outputs must clear before any clock.
        @(posedge clk); #2;
        a_drv = 16'h0F0F; b_drv = 16'h00FF; cin_drv = 1'b0; sub_drv = 1'b0; start_drv = 1'b1;
        @(posedge clk); #2;
        start_drv = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        $display("op reset_mid_run asserted at t=%0t", $time);
        set_lit("reset_mid_run", 16'h0000, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (18) @(posedge clk);
        #2;
        set_lit("no_done_after_rst", 16'h0000, 1'b0, 1'b0, 0);
        run_op("after_reset", 16'h0F0F, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h100E, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op("random", 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
